// File: rtl/pipeline_hazard_ctrl.sv
// Load-use, multiply-hold and branch/jump flush sequencer for the 5-stage pipeline.
// Optional statistics counters are enabled with the HAZ_STATS_EN macro.
module pipeline_hazard_ctrl #(
   parameter int unsigned MULT_LAT = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             IDEX_MemRead,
   input  logic [4:0]       IDEX_rt,
   input  logic             IDEX_MulOp,
   input  logic [4:0]       IFID_rs,
   input  logic [4:0]       IFID_rt,
   input  logic             IFID_UsesRt,
   input  logic             IFID_Jump,
   input  logic             EX_BranchTaken,
   output logic             PCWrite,
   output logic             IFID_Write,
   output logic             IFID_Flush,
   output logic             IDEX_Flush,
   output logic             EX_Hold,
   output logic             MulBusy,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   typedef enum logic [1:0] {StRun, StLuStall, StMulBusy} stateE;

   // First hold cycle is spent in StRun, so the busy phase counts down from MULT_LAT-2.
   localparam logic [3:0] CntInit = (MULT_LAT > 1) ? 4'(MULT_LAT - 2) : 4'd0;
   localparam bit         MulEn   = (MULT_LAT > 1);

   stateE      stateQ, stateD;
   logic [3:0] cntQ, cntD;
   logic       loadUse;

   assign loadUse = IDEX_MemRead && (IDEX_rt != 5'd0) &&
                    ((IDEX_rt == IFID_rs) || (IFID_UsesRt && (IDEX_rt == IFID_rt)));

   assign MulBusy = (stateQ == StMulBusy);

   always_comb begin
      PCWrite    = 1'b1;
      IFID_Write = 1'b1;
      IFID_Flush = 1'b0;
      IDEX_Flush = 1'b0;
      EX_Hold    = 1'b0;
      stateD     = stateQ;
      cntD       = cntQ;
      if (Reset) begin
         PCWrite    = 1'b0;
         IFID_Write = 1'b0;
         IFID_Flush = 1'b1;
         IDEX_Flush = 1'b1;
         stateD     = StRun;
         cntD       = 4'd0;
      end else if (EX_BranchTaken) begin
         IFID_Flush = 1'b1;
         IDEX_Flush = 1'b1;
         stateD     = StRun;
         cntD       = 4'd0;
      end else if (MulEn && (stateQ == StRun) && IDEX_MulOp) begin
         EX_Hold    = 1'b1;
         PCWrite    = 1'b0;
         IFID_Write = 1'b0;
         stateD     = StMulBusy;
         cntD       = CntInit;
      end else if (stateQ == StMulBusy) begin
         if (cntQ != 4'd0) begin
            EX_Hold    = 1'b1;
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
            cntD       = cntQ - 4'd1;
         end else begin
            stateD = StRun;
         end
      end else if (loadUse) begin
         PCWrite    = 1'b0;
         IFID_Write = 1'b0;
         IDEX_Flush = 1'b1;
         stateD     = StLuStall;
      end else begin
         stateD = StRun;
         if (IFID_Jump) begin
            IFID_Flush = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         stateQ <= StRun;
         cntQ   <= 4'd0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
      end
   end

`ifdef HAZ_STATS_EN
   logic [CNT_W-1:0] stallQ, flushQ;

   // Outside reset, IFID_Flush is raised only by a taken branch or a jump flush.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         stallQ <= '0;
         flushQ <= '0;
      end else begin
         if (!PCWrite && (stallQ != '1)) begin
            stallQ <= stallQ + 1'b1;
         end
         if (IFID_Flush && (flushQ != '1)) begin
            flushQ <= flushQ + 1'b1;
         end
      end
   end

   assign StallCount = stallQ;
   assign FlushCount = flushQ;
`else
   assign StallCount = '0;
   assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MULT_LAT=4, CNT_W=16).
module tb_pipeline_hazard_ctrl;

   logic        Clk, Reset;
   logic        IDEX_MemRead, IDEX_MulOp, IFID_UsesRt, IFID_Jump, EX_BranchTaken;
   logic [4:0]  IDEX_rt, IFID_rs, IFID_rt;
   logic        PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EX_Hold, MulBusy;
   logic [15:0] StallCount, FlushCount;

   int total = 0;
   int bad   = 0;
   int expSc = 0;
   int expFc = 0;

`ifdef HAZ_STATS_EN
   localparam bit StatsOn = 1'b1;
`else
   localparam bit StatsOn = 1'b0;
`endif

   pipeline_hazard_ctrl #(.MULT_LAT(4), .CNT_W(16)) dut (
      .Clk(Clk), .Reset(Reset),
      .IDEX_MemRead(IDEX_MemRead), .IDEX_rt(IDEX_rt), .IDEX_MulOp(IDEX_MulOp),
      .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IFID_UsesRt(IFID_UsesRt),
      .IFID_Jump(IFID_Jump), .EX_BranchTaken(EX_BranchTaken),
      .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
      .IDEX_Flush(IDEX_Flush), .EX_Hold(EX_Hold), .MulBusy(MulBusy),
      .StallCount(StallCount), .FlushCount(FlushCount)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // pcw, ifw, iff, idf, hold, busy
   task automatic chkOut(input string tag, input logic [5:0] exp);
      chk({tag, ".PCWrite"},    32'(PCWrite),    32'(exp[5]));
      chk({tag, ".IFID_Write"}, 32'(IFID_Write), 32'(exp[4]));
      chk({tag, ".IFID_Flush"}, 32'(IFID_Flush), 32'(exp[3]));
      chk({tag, ".IDEX_Flush"}, 32'(IDEX_Flush), 32'(exp[2]));
      chk({tag, ".EX_Hold"},    32'(EX_Hold),    32'(exp[1]));
      chk({tag, ".MulBusy"},    32'(MulBusy),    32'(exp[0]));
   endtask

   task automatic chkCnt(input string tag);
      chk({tag, ".StallCount"}, 32'(StallCount), StatsOn ? 32'(expSc) : 32'd0);
      chk({tag, ".FlushCount"}, 32'(FlushCount), StatsOn ? 32'(expFc) : 32'd0);
   endtask

   task automatic setIn(input logic mr, input logic [4:0] xrt, input logic mul,
                        input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                        input logic jmp, input logic br);
      IDEX_MemRead = mr;  IDEX_rt = xrt; IDEX_MulOp = mul;
      IFID_rs = rs; IFID_rt = rt; IFID_UsesRt = usesRt;
      IFID_Jump = jmp; EX_BranchTaken = br;
      #3;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset = 1'b1;
      setIn(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         setIn(1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom));
         chkOut("reset", 6'b001100);
         chkCnt("reset");
         tick();
      end
      Reset = 1'b0;
      setIn(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chkOut("run_after_reset", 6'b110000);
      tick();

      // Load-use on rs
      setIn(1'b1, 5'd8, 1'b0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
      chkOut("lu_rs", 6'b000100);
      tick(); expSc++;
      setIn(1'b0, 5'd8, 1'b0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
      chkOut("lu_rs_after", 6'b110000);
      chkCnt("lu_rs_after");
      tick();

      // Load-use on rt, only when rt is a source
      setIn(1'b1, 5'd5, 1'b0, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0);
      chkOut("lu_rt", 6'b000100);
      tick(); expSc++;
      setIn(1'b1, 5'd5, 1'b0, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0);
      chkOut("lu_rt_unused", 6'b110000);
      tick();

      // Register 0 never hazards
      setIn(1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      chkOut("lu_r0", 6'b110000);
      tick();

      // Multiply, 4 cycles in EX
      setIn(1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chkOut("mul_c1", 6'b000010);
      tick();
      setIn(1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chkOut("mul_c2", 6'b000011);
      tick();
      setIn(1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chkOut("mul_c3", 6'b000011);
      tick();
      setIn(1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chkOut("mul_c4", 6'b110001);
      tick(); expSc += 3;
      setIn(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chkOut("mul_done", 6'b110000);
      chkCnt("mul_done");
      tick();

      // Branch beats load-use
      setIn(1'b1, 5'd8, 1'b0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1);
      chkOut("br_vs_lu", 6'b111100);
      tick(); expFc++;
      setIn(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chkOut("br_after", 6'b110000);
      chkCnt("br_after");
      tick();

      // Jump suppressed under a load-use stall, fires in the next RUN cycle
      setIn(1'b1, 5'd8, 1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0);
      chkOut("jmp_stall", 6'b000100);
      tick(); expSc++;
      setIn(1'b0, 5'd8, 1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0);
      chkOut("jmp_run", 6'b111000);
      tick(); expFc++;

      // Persistent load-use re-stalls each cycle
      setIn(1'b1, 5'd9, 1'b0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
      chkOut("lu_pers1", 6'b000100);
      tick(); expSc++;
      setIn(1'b1, 5'd9, 1'b0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
      chkOut("lu_pers2", 6'b000100);
      tick(); expSc++;
      setIn(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chkOut("lu_pers_end", 6'b110000);
      chkCnt("lu_pers_end");
      tick();

      // Branch aborts MUL_BUSY with cnt=1
      setIn(1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chkOut("abort_c1", 6'b000010);
      tick();
      setIn(1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chkOut("abort_c2", 6'b000011);
      tick(); expSc += 2;
      setIn(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      chkOut("abort_br", 6'b111101);
      tick(); expFc++;
      setIn(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chkOut("abort_run", 6'b110000);
      chkCnt("abort_run");
      tick();

      // Reset mid-multiply aborts immediately
      setIn(1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      setIn(1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chkOut("rst_mul_busy", 6'b000011);
      Reset = 1'b1;
      #1;
      expSc = 0; expFc = 0;
      chkOut("rst_mul_abort", 6'b001100);
      chkCnt("rst_mul_abort");
      tick();
      Reset = 1'b0;
      setIn(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chkOut("rst_mul_run", 6'b110000);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall sequencer for the 5-stage MIPS pipeline. It watches the IF/ID and ID/EX pipeline registers and the EX-stage branch result, then drives the pipeline control signals:
- write enables for the PC and IF/ID register;
- flush (bubble-insert) controls for IF/ID and ID/EX;
- a hold for ID/EX and EX while a multi-cycle multiply occupies EX.

It sits beside the stage registers in the top-level datapath and is the only block that stalls or flushes them.

## Interface

Parameters:
- MULT_LAT, default 4: number of cycles a multiply occupies EX. Legal range 1..16.
- CNT_W, default 16: width of the statistics counters.

Ports:
- Clk  in  1  pipeline clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- IDEX_MemRead  in  1  the instruction in ID/EX is a load.
- IDEX_rt  in  5  destination register of the load in ID/EX.
- IDEX_MulOp  in  1  the instruction in ID/EX is a multi-cycle multiply.
- IFID_rs  in  5  rs field of the instruction in IF/ID.
- IFID_rt  in  5  rt field of the instruction in IF/ID.
- IFID_UsesRt  in  1  the IF/ID instruction reads rt as a source.
- IFID_Jump  in  1  the instruction in ID is j/jal/jr.
- EX_BranchTaken  in  1  the branch in EX resolved taken this cycle.
- PCWrite  out  1  PC load enable.
- IFID_Write  out  1  IF/ID load enable.
- IFID_Flush  out  1  zero the IF/ID instruction on the next edge.
- IDEX_Flush  out  1  zero the ID/EX control bits on the next edge (bubble).
- EX_Hold  out  1  ID/EX and the EX-stage multiplier keep their contents.
- MulBusy  out  1  the state machine is in MUL_BUSY.
- StallCount  out  CNT_W  cycles with PCWrite=0, excluding reset.
- FlushCount  out  CNT_W  branch and jump flush events.

## Operation

State machine: RUN, LU_STALL, MUL_BUSY. There is also a down-counter `cnt` of 4 bits.

Load-use condition, LU:
- IDEX_MemRead, and
- IDEX_rt != 0, and
- either (IDEX_rt == IFID_rs) or (IFID_UsesRt and IDEX_rt == IFID_rt).

Outputs are combinational from state and inputs. Default values: PCWrite=1, IFID_Write=1, IFID_Flush=0, IDEX_Flush=0, EX_Hold=0.

Priority, highest first:
1. **Reset high.** PCWrite=0, IFID_Write=0, IFID_Flush=1, IDEX_Flush=1, EX_Hold=0. State goes to RUN, cnt=0, counters=0.
2. **EX_BranchTaken.** IFID_Flush=1, IDEX_Flush=1, PCWrite=1. Next state is RUN from any state; this aborts MUL_BUSY.
3. **Multiply hold.**
   - In RUN with IDEX_MulOp and MULT_LAT>1: EX_Hold=1, PCWrite=0, IFID_Write=0. Next state MUL_BUSY, cnt=MULT_LAT-2.
   - In MUL_BUSY with cnt!=0: same outputs, and cnt decrements.
   - In MUL_BUSY with cnt==0: default outputs (release cycle; ID/EX advances). Next state RUN.
4. **LU in RUN or LU_STALL.** PCWrite=0, IFID_Write=0, IDEX_Flush=1. Next state LU_STALL.
5. **IFID_Jump.** IFID_Flush=1. This applies only when no higher rule stalls the front end.

Next-state summary:
- RUN goes to LU_STALL on LU.
- LU_STALL returns to RUN when LU is false.
- An LU that persists keeps the state in LU_STALL. It re-stalls each cycle; this is not an error.
- MULT_LAT=1: IDEX_MulOp is ignored and MUL_BUSY is never entered.

## Timing

- Flush and stall outputs are valid in the same cycle the inputs are presented. There is no added latency.
- Multiply: the multiply stays in EX for exactly MULT_LAT cycles, with EX_Hold high for the first MULT_LAT-1 of them.
- MulBusy is high from the cycle after entry through the release cycle, inclusive.
- Load-use: exactly one bubble per hazard. After the stall edge, ID/EX holds a bubble, so LU clears.
- Simultaneous branch and load-use: the branch wins. No LU_STALL entry and no stall cycle are counted.
- Reset asserted mid-MUL_BUSY: immediate abort. After release, the first cycle is RUN.

## Configuration

Macro: HAZ_STATS_EN.

With HAZ_STATS_EN defined:
- StallCount increments on every non-reset cycle with PCWrite=0.
- FlushCount increments on every cycle where EX_BranchTaken=1, or where rule 5 fires.
- Both counters saturate at 2^CNT_W-1.

Without HAZ_STATS_EN: both outputs are constant 0 and no counter flops are inferred. The ports exist in both builds.

## Test plan

- **Reset.** Hold Reset high 3 cycles with random inputs → PCWrite=0, IFID_Write=0, both flushes=1, MulBusy=0, counters=0. On release → state RUN.
- **Load-use.** IDEX_MemRead=1, IDEX_rt=8, IFID_rs=8 → one cycle with PCWrite=0, IFID_Write=0, IDEX_Flush=1. Next cycle with MemRead=0 → defaults. StallCount=1.
- **Load-use, register 0.** Same as above with IDEX_rt=0 → no stall.
- **Multiply, MULT_LAT=4.** IDEX_MulOp held high → EX_Hold high for exactly 3 cycles, then released on the 4th. MulBusy high on cycles 2..4. StallCount=3.
- **Branch vs load-use.** EX_BranchTaken=1 together with an LU → IFID_Flush=1, IDEX_Flush=1, PCWrite=1, no stall. FlushCount increments by 1.
- **Jump under stall, and branch abort.** IFID_Jump=1 during a load-use stall → IFID_Flush=0 that cycle. Flush fires in the following RUN cycle. EX_BranchTaken during MUL_BUSY with cnt=1 → next state RUN and EX_Hold=0.
